// File: rtl/cfa_pkg.sv
// Shared constants, FSM encoding and window bit-index helper for the raw window
// fetcher that feeds the CFA demosaic core.
package cfa_pkg;

    localparam int unsigned PIX_W  = 12;
    localparam int unsigned DIM_W  = 11;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned WIN    = 5;

    typedef enum logic [2:0] {
        StIdle,
        StPrime,
        StFetch,
        StEmit,
        StDone
    } state_e;

    // LSB of element [i][j] within the flat window bus.
    function automatic int unsigned win_lsb(input int i, input int j, input int unsigned pix_w);
        return (int'(i) * int'(WIN) + int'(j)) * int'(pix_w);
    endfunction

endpackage

// File: rtl/raw_mirror_addr.sv
// Combinational Bayer-phase-preserving edge mirror for signed row/column
// indices, producing the raw memory address of the mirrored pixel.
module raw_mirror_addr import cfa_pkg::*; #(
    parameter int unsigned DIM_W  = 11,
    parameter int unsigned ADDR_W = 17
) (
    input  logic signed [DIM_W+1:0] row_idx_i,
    input  logic signed [DIM_W+1:0] col_idx_i,
    input  logic [DIM_W-1:0]        row_max_i,
    input  logic [DIM_W-1:0]        col_max_i,
    output logic [ADDR_W-1:0]       addr_o
);

    // Reflect about pixel 0 and pixel n-1 without repeating the edge pixel,
    // which keeps the Bayer phase intact.
    function automatic logic [DIM_W-1:0] mirror(input logic signed [DIM_W+1:0] idx,
                                                 input logic [DIM_W-1:0] n);
        logic signed [DIM_W+1:0] nn;
        logic signed [DIM_W+1:0] res;
        nn = $signed({2'b00, n});
        if (idx[DIM_W+1]) begin
            res = -idx;
        end else if (idx >= nn) begin
            res = (nn <<< 1) - $signed((DIM_W+2)'(2)) - idx;
        end else begin
            res = idx;
        end
        return DIM_W'(res);
    endfunction

    logic [DIM_W-1:0] row_m;
    logic [DIM_W-1:0] col_m;

    always_comb begin
        row_m  = mirror(row_idx_i, row_max_i);
        col_m  = mirror(col_idx_i, col_max_i);
        addr_o = ADDR_W'(64'(row_m) * 64'(col_max_i) + 64'(col_m));
    end

endmodule

// File: rtl/raw_window_fetch.sv
// Reads a raw Bayer frame one pixel per memory cycle and assembles a mirrored
// 5x5 window per output pixel in raster order, with valid/ready output.
module raw_window_fetch import cfa_pkg::*; #(
    parameter int unsigned PIX_W  = cfa_pkg::PIX_W,
    parameter int unsigned DIM_W  = cfa_pkg::DIM_W,
    parameter int unsigned ADDR_W = cfa_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DIM_W-1:0]         rowMax,
    input  logic [DIM_W-1:0]         colMax,
    input  logic [PIX_W-1:0]         raw,
    output logic [ADDR_W-1:0]        readAddress,
    output logic [WIN*WIN*PIX_W-1:0] window,
    output logic                     winValid,
    input  logic                     winReady,
    output logic                     rowUpdate,
    output logic                     colUpdate,
    output logic [DIM_W-1:0]         outRow,
    output logic [DIM_W-1:0]         outCol,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam logic [63:0] MaxPix = 64'd1 << ADDR_W;

    state_e           state_q, state_d;
    logic [DIM_W-1:0] row_max_q, row_max_d;
    logic [DIM_W-1:0] col_max_q, col_max_d;
    logic [DIM_W-1:0] r_q, r_d;
    logic [DIM_W-1:0] c_q, c_d;
    logic [2:0]       k_q, k_d;
    logic [1:0]       pc_q, pc_d;
    logic             err_q, err_d;
    logic [PIX_W-1:0] stage_q [WIN-1];
    logic [PIX_W-1:0] stage_d [WIN-1];
    logic [PIX_W-1:0] win_q [WIN][WIN];
    logic [PIX_W-1:0] win_d [WIN][WIN];

    logic                    dims_bad;
    logic                    reading;
    logic signed [DIM_W+1:0] row_idx;
    logic signed [DIM_W+1:0] col_idx;
    logic [ADDR_W-1:0]       mirror_addr;

    assign dims_bad = (rowMax < DIM_W'(3)) || (colMax < DIM_W'(3)) ||
                      ((64'(rowMax) * 64'(colMax)) > MaxPix);
    assign reading  = (state_q == StPrime) || (state_q == StFetch);

    // PRIME walks columns c-2..c+1; FETCH reads only the new column c+2.
    always_comb begin
        row_idx = $signed({2'b00, r_q}) + $signed((DIM_W+2)'(k_q)) - $signed((DIM_W+2)'(2));
        if (state_q == StPrime) begin
            col_idx = $signed({2'b00, c_q}) + $signed((DIM_W+2)'(pc_q)) -
                      $signed((DIM_W+2)'(2));
        end else begin
            col_idx = $signed({2'b00, c_q}) + $signed((DIM_W+2)'(2));
        end
    end

    raw_mirror_addr #(
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) u_mirror (
        .row_idx_i (row_idx),
        .col_idx_i (col_idx),
        .row_max_i (row_max_q),
        .col_max_i (col_max_q),
        .addr_o    (mirror_addr)
    );

    always_comb begin
        state_d   = state_q;
        row_max_d = row_max_q;
        col_max_d = col_max_q;
        r_d       = r_q;
        c_d       = c_q;
        k_d       = k_q;
        pc_d      = pc_q;
        err_d     = 1'b0;
        stage_d   = stage_q;
        win_d     = win_q;

        // Fifth read of a column: shift window left, staged column enters at col 4.
        if (reading) begin
            if (k_q == 3'd4) begin
                for (int i = 0; i < WIN; i++) begin
                    for (int j = 0; j < WIN - 1; j++) begin
                        win_d[i][j] = win_q[i][j+1];
                    end
                    win_d[i][WIN-1] = (i < WIN - 1) ? stage_q[i] : raw;
                end
            end else begin
                stage_d[k_q[1:0]] = raw;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (dims_bad) begin
                        err_d = 1'b1;
                    end else begin
                        row_max_d = rowMax;
                        col_max_d = colMax;
                        r_d       = '0;
                        c_d       = '0;
                        k_d       = '0;
                        pc_d      = '0;
                        state_d   = StPrime;
                    end
                end
            end
            StPrime: begin
                if (k_q == 3'd4) begin
                    k_d = '0;
                    if (pc_q == 2'd3) begin
                        pc_d    = '0;
                        state_d = StFetch;
                    end else begin
                        pc_d = pc_q + 2'd1;
                    end
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            StFetch: begin
                if (k_q == 3'd4) begin
                    k_d     = '0;
                    state_d = StEmit;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            StEmit: begin
                if (winReady) begin
                    if (c_q < col_max_q - DIM_W'(1)) begin
                        c_d     = c_q + DIM_W'(1);
                        state_d = StFetch;
                    end else if (r_q < row_max_q - DIM_W'(1)) begin
                        c_d     = '0;
                        r_d     = r_q + DIM_W'(1);
                        state_d = StPrime;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            row_max_q <= '0;
            col_max_q <= '0;
            r_q       <= '0;
            c_q       <= '0;
            k_q       <= '0;
            pc_q      <= '0;
            err_q     <= 1'b0;
            stage_q   <= '{default: '0};
            win_q     <= '{default: '{default: '0}};
        end else begin
            state_q   <= state_d;
            row_max_q <= row_max_d;
            col_max_q <= col_max_d;
            r_q       <= r_d;
            c_q       <= c_d;
            k_q       <= k_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
            stage_q   <= stage_d;
            win_q     <= win_d;
        end
    end

    always_comb begin
        window = '0;
        for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN; j++) begin
                window[win_lsb(i, j, PIX_W) +: PIX_W] = win_q[i][j];
            end
        end
    end

    assign readAddress = reading ? mirror_addr : '0;
    assign winValid    = (state_q == StEmit);
    assign colUpdate   = winValid & winReady;
    assign rowUpdate   = winValid & (c_q == '0);
    assign outRow      = r_q;
    assign outCol      = c_q;
    assign busy        = reading || (state_q == StEmit);
    assign done        = (state_q == StDone);
    assign err         = err_q;

endmodule

// File: tb/tb_raw_window_fetch.sv
// Directed bench for raw_window_fetch: memory returns the low address bits, so
// every window element is predictable from its mirrored coordinates.
module tb_raw_window_fetch;

    localparam int PW = 12;
    localparam int DW = 11;
    localparam int AW = 17;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DW-1:0]     rowMax;
    logic [DW-1:0]     colMax;
    logic [PW-1:0]     raw;
    logic [AW-1:0]     readAddress;
    logic [25*PW-1:0]  window;
    logic              winValid;
    logic              winReady;
    logic              rowUpdate;
    logic              colUpdate;
    logic [DW-1:0]     outRow;
    logic [DW-1:0]     outCol;
    logic              busy;
    logic              done;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_col     = 0;
    int n_row     = 0;
    int n_oob     = 0;
    int n_cen_bad = 0;

    always #5 clk = ~clk;

    assign raw = readAddress[PW-1:0];

    raw_window_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rowMax      (rowMax),
        .colMax      (colMax),
        .raw         (raw),
        .readAddress (readAddress),
        .window      (window),
        .winValid    (winValid),
        .winReady    (winReady),
        .rowUpdate   (rowUpdate),
        .colUpdate   (colUpdate),
        .outRow      (outRow),
        .outCol      (outCol),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    function automatic logic [PW-1:0] w(input int i, input int j);
        return window[(i*5+j)*PW +: PW];
    endfunction

    // Mid-cycle tallies of strobes, address range and centre pixel.
    always @(negedge clk) begin
        if (colUpdate) n_col <= n_col + 1;
        if (rowUpdate) n_row <= n_row + 1;
        if (busy && (int'(readAddress) >= int'(rowMax) * int'(colMax))) n_oob <= n_oob + 1;
        if (winValid && (w(2, 2) !== 12'(int'(outRow) * int'(colMax) + int'(outCol))))
            n_cen_bad <= n_cen_bad + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int rows, input int cols);
        rowMax = DW'(rows);
        colMax = DW'(cols);
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        while (!winValid && cyc < limit) begin
            step();
            cyc++;
        end
        check("wait_valid_timeout", 64'(cyc < limit), 1);
    endtask

    task automatic wait_win(input int row, input int col, input int limit, output int cyc);
        cyc = 0;
        while (!(winValid && int'(outRow) == row && int'(outCol) == col) && cyc < limit) begin
            step();
            cyc++;
        end
        check("wait_win_timeout", 64'(cyc < limit), 1);
    endtask

    task automatic finish_frame(input int limit, input int restart_at, inout int cyc,
                                output logic [PW-1:0] l44, output logic [PW-1:0] l23,
                                output logic [PW-1:0] l22);
        l44 = '0;
        l23 = '0;
        l22 = '0;
        while (!done && cyc < limit) begin
            if (cyc == restart_at) start = 1'b1;
            step();
            start = 1'b0;
            cyc++;
            if (winValid && int'(outRow) == int'(rowMax) - 1 && int'(outCol) == int'(colMax) - 1)
            begin
                l44 = w(4, 4);
                l23 = w(2, 3);
                l22 = w(2, 2);
            end
        end
        check("done_timeout", 64'(cyc < limit), 1);
    endtask

    task automatic check_first(input int cyc);
        check("first_valid_cycle", 64'(cyc + 1), 26);
        check("first_valid",       64'(winValid), 1);
        check("first_w22",         64'(w(2, 2)), 0);
        check("first_w00",         64'(w(0, 0)), 18);
        check("first_w13",         64'(w(1, 3)), 9);
        check("first_rowupd",      64'(rowUpdate), 1);
        check("first_outrow",      64'(outRow), 0);
        check("first_outcol",      64'(outCol), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_window"}, 64'(window === '0), 1);
        check({tag, "_addr"},   64'(readAddress), 0);
        check({tag, "_valid"},  64'(winValid), 0);
        check({tag, "_busy"},   64'(busy), 0);
        check({tag, "_outrow"}, 64'(outRow), 0);
        check({tag, "_outcol"}, 64'(outCol), 0);
        check({tag, "_colupd"}, 64'(colUpdate), 0);
        check({tag, "_rowupd"}, 64'(rowUpdate), 0);
        check({tag, "_done"},   64'(done), 0);
        check({tag, "_err"},    64'(err), 0);
    endtask

    initial begin
        int cyc;
        int col0, row0, oob0, cen0;
        logic [PW-1:0]    l44, l23, l22;
        logic [25*PW-1:0] wsave;
        logic [AW-1:0]    asave;

        rst      = 1'b1;
        start    = 1'b0;
        rowMax   = '0;
        colMax   = '0;
        winReady = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_all_zero("reset");

        // Full 8x8 frame, ready tied high.
        col0 = n_col; row0 = n_row; oob0 = n_oob; cen0 = n_cen_bad;
        pulse_start(8, 8);
        check("a_busy", 64'(busy), 1);
        wait_valid(100, cyc);
        check_first(cyc);
        finish_frame(2000, -1, cyc, l44, l23, l22);
        check("a_done_cycle", 64'(cyc), 544);
        check("a_last_w44",   64'(l44), 45);
        check("a_last_w23",   64'(l23), 62);
        check("a_last_w22",   64'(l22), 63);
        check("a_done_busy",  64'(busy), 0);
        step();
        check("a_done_pulse", 64'(done), 0);
        check("a_colupd_cnt", 64'(n_col - col0), 64);
        check("a_rowupd_cnt", 64'(n_row - row0), 8);
        check("a_oob",        64'(n_oob - oob0), 0);
        check("a_centre",     64'(n_cen_bad - cen0), 0);

        // Back-pressure at window (3,4).
        pulse_start(8, 8);
        wait_win(3, 4, 1000, cyc);
        winReady = 1'b0;
        wsave = window;
        asave = readAddress;
        check("bp_w22", 64'(w(2, 2)), 28);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid",  64'(winValid), 1);
            check("bp_window", 64'(window === wsave), 1);
            check("bp_addr",   64'(readAddress), 64'(asave));
            check("bp_colupd", 64'(colUpdate), 0);
            check("bp_outcol", 64'(outCol), 4);
        end
        winReady = 1'b1;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!winValid && cyc < 50);
        check("bp_resume_cycles", 64'(cyc), 6);
        check("bp_resume_row",    64'(outRow), 3);
        check("bp_resume_col",    64'(outCol), 5);
        check("bp_resume_w22",    64'(w(2, 2)), 29);
        check("bp_resume_w24",    64'(w(2, 4)), 31);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Reset at window 20, i.e. (2,4).
        pulse_start(8, 8);
        wait_win(2, 4, 1000, cyc);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("midrst");

        // Fresh frame after reset; a second start mid-frame must be ignored.
        col0 = n_col; row0 = n_row; cen0 = n_cen_bad;
        pulse_start(8, 8);
        wait_valid(100, cyc);
        check_first(cyc);
        finish_frame(2000, 100, cyc, l44, l23, l22);
        check("d_done_cycle", 64'(cyc), 544);
        check("d_colupd_cnt", 64'(n_col - col0), 64);
        check("d_rowupd_cnt", 64'(n_row - row0), 8);
        check("d_centre",     64'(n_cen_bad - cen0), 0);
        step();

        // Rejected starts.
        pulse_start(8, 2);
        check("err_col2",      64'(err), 1);
        check("err_col2_busy", 64'(busy), 0);
        check("err_col2_addr", 64'(readAddress), 0);
        step();
        check("err_col2_pulse", 64'(err), 0);
        check("err_col2_busy2", 64'(busy), 0);
        pulse_start(2, 8);
        check("err_row2", 64'(err), 1);
        step();
        pulse_start(257, 512);
        check("err_big", 64'(err), 1);
        check("err_big_busy", 64'(busy), 0);
        step();
        pulse_start(256, 512);
        check("ok_max_err",  64'(err), 0);
        check("ok_max_busy", 64'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Smallest legal frame: every window is mirrored on both axes.
        col0 = n_col; row0 = n_row; oob0 = n_oob; cen0 = n_cen_bad;
        pulse_start(3, 3);
        wait_valid(100, cyc);
        check("s3_w00", 64'(w(0, 0)), 8);
        check("s3_w44", 64'(w(4, 4)), 8);
        finish_frame(1000, -1, cyc, l44, l23, l22);
        check("s3_done_cycle", 64'(cyc), 114);
        check("s3_last_w44",   64'(l44), 0);
        check("s3_last_w23",   64'(l23), 7);
        step();
        check("s3_colupd_cnt", 64'(n_col - col0), 9);
        check("s3_rowupd_cnt", 64'(n_row - row0), 3);
        check("s3_oob",        64'(n_oob - oob0), 0);
        check("s3_centre",     64'(n_cen_bad - cen0), 0);

        // 70x70 frame.
        col0 = n_col; row0 = n_row; oob0 = n_oob; cen0 = n_cen_bad;
        pulse_start(70, 70);
        cyc = 0;
        finish_frame(40000, -1, cyc, l44, l23, l22);
        check("big_done_cycle", 64'(cyc), 30800);
        step();
        check("big_colupd_cnt", 64'(n_col - col0), 4900);
        check("big_rowupd_cnt", 64'(n_row - row0), 70);
        check("big_oob",        64'(n_oob - oob0), 0);
        check("big_centre",     64'(n_cen_bad - cen0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/raw_window_fetch.md
Name: raw_window_fetch

Overview:
Upstream feeder for the CFA demosaic core. Reads the raw Bayer frame from single-port memory (combinational read data) in 6-cycle-per-pixel cadence and assembles a 5x5 neighbourhood per output pixel in raster order. Frame edges use Bayer-phase-preserving mirroring, so the core never sees out-of-frame pixels. Output is a flat window bus with valid/ready handshake plus row/column update strobes.

Parameters:
PIX_W, 12, raw pixel width
DIM_W, 11, width of rowMax/colMax and coordinates
ADDR_W, 17, raw memory address width

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle frame start pulse
rowMax  in  DIM_W  frame height in pixels, latched at start
colMax  in  DIM_W  frame width in pixels, latched at start
raw  in  PIX_W  raw memory read data, valid in the same cycle as readAddress
readAddress  out  ADDR_W  raw memory address = mirrored_row*colMax + mirrored_col
window  out  25*PIX_W  5x5 window; element [i][j] (row i, col j) at bits (i*5+j)*PIX_W; [2][2] is centre
winValid  out  1  window valid
winReady  in  1  downstream accepts window
rowUpdate  out  1  high with winValid when centre column is 0
colUpdate  out  1  winValid & winReady (one per accepted window)
outRow, outCol  out  DIM_W each  centre coordinates of current window
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last window is accepted
err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Single clock; reset is synchronous, active-high. Reset forces IDLE; all outputs 0 (window, readAddress, strobes, coordinates), regardless of state.
- Mirror m(i,N): i<0 -> -i; i>=N -> 2N-2-i; else i. Applied to row (N=rowMax) and column (N=colMax).
- IDLE: on start, if rowMax<3 or colMax<3 or rowMax*colMax > 2^ADDR_W -> err pulse, stay IDLE. Else latch dims, r=c=0, busy=1, go PRIME. start while busy is ignored.
- PRIME (20 cycles): columns c-2..c+1, each read rows r-2..r+2 top-to-bottom (column-major); window shifts left one column after each 5th read. Then FETCH.
- FETCH (5 cycles): k=0..4 reads (m(r-2+k), m(c+2)); raw captured each cycle into column staging; at k=4 window shifts left and staging+raw become column 4. Then EMIT.
- EMIT: winValid=1, window/outRow/outCol stable. If winReady=0, hold everything (readAddress unchanged, no strobes). If winReady=1: colUpdate=1; if c<colMax-1 then c++ -> FETCH; else if r<rowMax-1 then c=0, r++ -> PRIME; else -> DONE.
- DONE: done=1 for one cycle, busy=0, -> IDLE.
- Timing with winReady tied high: start sampled at edge E0; PRIME cycles 1-20, FETCH 21-25, first winValid in cycle 26. Per row 20+6*colMax cycles.
- readAddress in IDLE/DONE/EMIT holds 0. Product uses full-width multiply, truncated to ADDR_W (guaranteed in range by start check).

Decomposition:
- Shared package cfa_pkg: PIX_W, DIM_W, ADDR_W, WIN=5, state encoding (IDLE, PRIME, FETCH, EMIT, DONE), window bit-index function.
- One sub-module raw_mirror_addr: combinational; signed row/col offsets + dims -> mirrored coordinates and readAddress.

Test Plan:
- 8x8 frame, mem[a]=a, winReady=1: first winValid in cycle 26 after start; window[2][2]=0, [0][0]=18, [1][3]=9, rowUpdate=1, outRow=outCol=0.
- Same frame, last window (7,7): window[4][4]=45, [2][3]=62, [2][2]=63. Exactly 64 colUpdate pulses and 8 rowUpdate pulses; done pulses one cycle after the last handshake, 544 cycles after start+1.
- Back-pressure: winReady low 10 cycles at window (3,4). winValid stays 1; window and readAddress stay stable; no colUpdate. Resumes to (3,5) after 6 cycles once ready.
- Reset mid-frame at window 20: the next cycle shows all outputs 0 and busy=0. A fresh start gives its first window again at cycle 26 with the same values as test 1.
- start with colMax=2 -> err=1 for one cycle; busy stays 0; readAddress stays 0. A second start during a valid frame is ignored (window count is unchanged).
- 70x70 frame: 4900 colUpdate pulses, 70 rowUpdate pulses; readAddress never ≥4900; centre pixel of each window equals mem[outRow*70+outCol].
